gpr_wb_arbiter: RTL and testbench

- Writer end of the GPR write port (WE/RW/WD/pc); owns every write into the register file.
- Merges two result sources:
  - the main pipeline's W stage, which is never stalled;
  - the multi-cycle mult/div unit, through a valid/ready handshake.
- Buffers MD results in a small queue and drains them into free write slots.
- Reports per-register pending status to the D-stage hazard unit.

---
 rtl/gpr_wb_arbiter_pkg.sv | 17 +
 rtl/gpr_wb_queue.sv | 81 ++++++++
 rtl/gpr_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_gpr_wb_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared types for the GPR write-back arbiter.
// Holds the register-index and data widths, and the layout of one queued
// mult/div result.
package gpr_wb_arbiter_pkg;

  localparam int unsigned RegW  = 5;
  localparam int unsigned DataW = 32;

  // live is cleared when a younger pipe write to the same register squashes it
  typedef struct packed {
    logic             live;
    logic [RegW-1:0]  rw;
    logic [DataW-1:0] wd;
    logic [DataW-1:0] pc;
  } md_entry_t;

endpackage

// File: rtl/gpr_wb_queue.sv
// FIFO of mult/div results awaiting a free GPR write slot.
// Ports:
//   clk, reset              clock, async active-high reset
//   i_push, i_entry         store i_entry at tail (caller guarantees !o_full)
//   i_pop                   retire head (caller guarantees !o_empty)
//   i_squash, i_squash_rw   kill every queued entry targeting i_squash_rw
//   i_qa, i_qb              hazard query addresses
//   o_full, o_empty         occupancy flags
//   o_head                  entry at head
//   o_pend_a, o_pend_b      a live entry targets i_qa / i_qb (register 0 never pends)
module gpr_wb_queue
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PW    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_push,
  input  md_entry_t       i_entry,
  input  logic            i_pop,
  input  logic            i_squash,
  input  logic [RegW-1:0] i_squash_rw,
  input  logic [RegW-1:0] i_qa,
  input  logic [RegW-1:0] i_qb,
  output logic            o_full,
  output logic            o_empty,
  output md_entry_t       o_head,
  output logic            o_pend_a,
  output logic            o_pend_b
);

  md_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_squash && r_mem[i].rw == i_squash_rw) r_mem[i].live <= 1'b0;
      end
      // Popped slots are marked dead so pending lookup can scan all slots.
      if (i_pop) begin
        r_mem[r_head].live <= 1'b0;
        r_head             <= r_head + 1'b1;
      end
      // Written last: a same-cycle enqueue is younger than the squashing pipe write.
      if (i_push) begin
        r_mem[r_tail] <= i_entry;
        r_tail        <= r_tail + 1'b1;
      end
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full  = (r_count == (PW + 1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_head];

  always_comb begin
    o_pend_a = 1'b0;
    o_pend_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_mem[i].live && r_mem[i].rw == i_qa) o_pend_a = 1'b1;
      if (r_mem[i].live && r_mem[i].rw == i_qb) o_pend_b = 1'b1;
    end
    if (i_qa == '0) o_pend_a = 1'b0;
    if (i_qb == '0) o_pend_b = 1'b0;
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Sole writer of the GPR write port. The never-stalled pipeline W stage has
// priority; mult/div results are queued and drained into idle slots.
// Ports:
//   clk, reset                         clock, async active-high reset
//   pipe_we/rw/wd/pc                   pipeline W-stage write request
//   md_valid/md_ready, md_rw/wd/pc     mult/div result handshake
//   qa, qb -> pend_a, pend_b           per-register pending status for hazards
//   WE, RW, WD, pc                     registered GPR write port
// Optional: define GPR_WB_TRACE_EN to print one line per committed write.
module gpr_wb_arbiter
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pipe_we,
  input  logic [RegW-1:0]  pipe_rw,
  input  logic [DataW-1:0] pipe_wd,
  input  logic [DataW-1:0] pipe_pc,
  input  logic             md_valid,
  output logic             md_ready,
  input  logic [RegW-1:0]  md_rw,
  input  logic [DataW-1:0] md_wd,
  input  logic [DataW-1:0] md_pc,
  input  logic [RegW-1:0]  qa,
  input  logic [RegW-1:0]  qb,
  output logic             pend_a,
  output logic             pend_b,
  output logic             WE,
  output logic [RegW-1:0]  RW,
  output logic [DataW-1:0] WD,
  output logic [DataW-1:0] pc
);

  logic             w_full;
  logic             w_empty;
  md_entry_t        w_head;
  md_entry_t        w_entry;
  logic             w_pipe_wr;
  logic             w_push;
  logic             w_pop;
  logic             w_we_d;
  logic [RegW-1:0]  w_rw_d;
  logic [DataW-1:0] w_wd_d;
  logic [DataW-1:0] w_pc_d;

  logic             r_we;
  logic [RegW-1:0]  r_rw;
  logic [DataW-1:0] r_wd;
  logic [DataW-1:0] r_pc;

  assign md_ready  = !w_full;
  assign w_pipe_wr = pipe_we && (pipe_rw != '0);
  // Writes to $0 complete the handshake but are dropped.
  assign w_push    = md_valid && md_ready && (md_rw != '0);
  assign w_pop     = !w_pipe_wr && !w_empty;
  assign w_entry   = '{live: 1'b1, rw: md_rw, wd: md_wd, pc: md_pc};

  gpr_wb_queue #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_entry     (w_entry),
    .i_pop       (w_pop),
    .i_squash    (w_pipe_wr),
    .i_squash_rw (pipe_rw),
    .i_qa        (qa),
    .i_qb        (qb),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (w_head),
    .o_pend_a    (pend_a),
    .o_pend_b    (pend_b)
  );

  // A dead head still consumes the slot, but issues no write.
  always_comb begin
    w_we_d = 1'b0;
    w_rw_d = r_rw;
    w_wd_d = r_wd;
    w_pc_d = r_pc;
    if (w_pipe_wr) begin
      w_we_d = 1'b1;
      w_rw_d = pipe_rw;
      w_wd_d = pipe_wd;
      w_pc_d = pipe_pc;
    end else if (w_pop && w_head.live) begin
      w_we_d = 1'b1;
      w_rw_d = w_head.rw;
      w_wd_d = w_head.wd;
      w_pc_d = w_head.pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we <= 1'b0;
      r_rw <= '0;
      r_wd <= '0;
      r_pc <= '0;
    end else begin
      r_we <= w_we_d;
      r_rw <= w_rw_d;
      r_wd <= w_wd_d;
      r_pc <= w_pc_d;
    end
  end

  assign WE = r_we;
  assign RW = r_rw;
  assign WD = r_wd;
  assign pc = r_pc;

`ifdef GPR_WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && w_we_d) $display("%d@%h: $%d <= %h", $time, w_pc_d, w_rw_d, w_wd_d);
  end
`else
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
module tb_gpr_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_rw = '0;
  logic [31:0] pipe_wd = '0;
  logic [31:0] pipe_pc = '0;
  logic        md_valid = 1'b0;
  logic        md_ready;
  logic [4:0]  md_rw = '0;
  logic [31:0] md_wd = '0;
  logic [31:0] md_pc = '0;
  logic [4:0]  qa = '0;
  logic [4:0]  qb = '0;
  logic        pend_a;
  logic        pend_b;
  logic        WE;
  logic [4:0]  RW;
  logic [31:0] WD;
  logic [31:0] pc;

  int checks   = 0;
  int failures = 0;

  gpr_wb_arbiter #(
    .DEPTH (4),
    .PW    (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pipe_we  (pipe_we),
    .pipe_rw  (pipe_rw),
    .pipe_wd  (pipe_wd),
    .pipe_pc  (pipe_pc),
    .md_valid (md_valid),
    .md_ready (md_ready),
    .md_rw    (md_rw),
    .md_wd    (md_wd),
    .md_pc    (md_pc),
    .qa       (qa),
    .qb       (qb),
    .pend_a   (pend_a),
    .pend_b   (pend_b),
    .WE       (WE),
    .RW       (RW),
    .WD       (WD),
    .pc       (pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_we  = 1'b0;
    md_valid = 1'b0;
  endtask

  int k;

  initial begin
    // Asynchronous reset before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("rst_we", 32'(WE), 32'd0);
    check("rst_rw", 32'(RW), 32'd0);
    check("rst_wd", WD, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_ready", 32'(md_ready), 32'd1);
    check("rst_pend", {30'd0, pend_a, pend_b}, 32'd0);
    cyc();
    reset = 1'b0;

    // Pipe write: 1-cycle latency, then WE drops, address/data hold.
    pipe_we = 1'b1; pipe_rw = 5'd5; pipe_wd = 32'h1234; pipe_pc = 32'h100;
    cyc();
    check("pipe_we", 32'(WE), 32'd1);
    check("pipe_rw", 32'(RW), 32'd5);
    check("pipe_wd", WD, 32'h0000_1234);
    check("pipe_pc", pc, 32'h100);
    idle();
    cyc();
    check("pipe_idle_we", 32'(WE), 32'd0);
    check("pipe_hold_rw", 32'(RW), 32'd5);

    // Single MD result: pending after accept, write 2 cycles after accept.
    md_valid = 1'b1; md_rw = 5'd8; md_wd = 32'hAAAA_0000; md_pc = 32'h200;
    qa = 5'd8; qb = 5'd8;
    #1 check("md_pend_pre", 32'(pend_a), 32'd0);
    cyc();
    idle();
    check("md_pend_a", 32'(pend_a), 32'd1);
    check("md_pend_b", 32'(pend_b), 32'd1);
    check("md_we_e1", 32'(WE), 32'd0);
    cyc();
    check("md_we_e2", 32'(WE), 32'd1);
    check("md_rw_e2", 32'(RW), 32'd8);
    check("md_wd_e2", WD, 32'hAAAA_0000);
    check("md_pc_e2", pc, 32'h200);
    check("md_pend_clr", 32'(pend_a), 32'd0);

    // Pipe busy 6 cycles, MD offers 5: 4 accepted, drained in order afterwards.
    k  = 0;
    qa = 5'd10;
    for (int i = 0; i < 6; i++) begin
      pipe_we = 1'b1; pipe_rw = 5'(i + 1); pipe_wd = 32'h100 + 32'(i); pipe_pc = 32'h400;
      md_valid = 1'b1; md_rw = 5'(10 + k); md_wd = 32'hB0 + 32'(k); md_pc = 32'h300 + 32'(k);
      #1 check("full_ready", 32'(md_ready), (k < 4) ? 32'd1 : 32'd0);
      if (k < 4) k++;
      cyc();
      check("busy_we", 32'(WE), 32'd1);
      check("busy_rw", 32'(RW), 32'(i + 1));
    end
    check("busy_pend10", 32'(pend_a), 32'd1);
    idle();
    for (int j = 0; j < 4; j++) begin
      cyc();
      check("drain_we", 32'(WE), 32'd1);
      check("drain_rw", 32'(RW), 32'(10 + j));
      check("drain_wd", WD, 32'hB0 + 32'(j));
    end
    cyc();
    check("drain_done_we", 32'(WE), 32'd0);
    check("drain_ready", 32'(md_ready), 32'd1);

    // WAW squash of a queued entry.
    md_valid = 1'b1; md_rw = 5'd9; md_wd = 32'h1; md_pc = 32'h500;
    qa = 5'd9;
    cyc();
    idle();
    check("sq_pend", 32'(pend_a), 32'd1);
    pipe_we = 1'b1; pipe_rw = 5'd9; pipe_wd = 32'h2; pipe_pc = 32'h504;
    cyc();
    idle();
    check("sq_we", 32'(WE), 32'd1);
    check("sq_wd", WD, 32'h2);
    check("sq_pend_clr", 32'(pend_a), 32'd0);
    cyc();
    check("sq_dead_we", 32'(WE), 32'd0);
    check("sq_dead_wd", WD, 32'h2);

    // Same-cycle enqueue to the pipe's register survives the squash.
    pipe_we = 1'b1; pipe_rw = 5'd7; pipe_wd = 32'h70; pipe_pc = 32'h600;
    md_valid = 1'b1; md_rw = 5'd7; md_wd = 32'h77; md_pc = 32'h604;
    qa = 5'd7;
    cyc();
    idle();
    check("same_wd", WD, 32'h70);
    check("same_pend", 32'(pend_a), 32'd1);
    cyc();
    check("same_md_we", 32'(WE), 32'd1);
    check("same_md_rw", 32'(RW), 32'd7);
    check("same_md_wd", WD, 32'h77);

    // Register 0 from either source never writes and never pends.
    pipe_we = 1'b1; pipe_rw = 5'd0; pipe_wd = 32'hDEAD;
    md_valid = 1'b1; md_rw = 5'd0; md_wd = 32'hBEEF;
    qa = 5'd0;
    #1 check("r0_ready", 32'(md_ready), 32'd1);
    cyc();
    idle();
    check("r0_we1", 32'(WE), 32'd0);
    check("r0_pend", 32'(pend_a), 32'd0);
    cyc();
    check("r0_we2", 32'(WE), 32'd0);
    check("r0_wd_hold", WD, 32'h77);

    // Reset mid-operation with 3 queued entries.
    qb = 5'd20;
    for (int i = 0; i < 3; i++) begin
      pipe_we = 1'b1; pipe_rw = 5'd1; pipe_wd = 32'h11;
      md_valid = 1'b1; md_rw = 5'(20 + i); md_wd = 32'hC0 + 32'(i);
      cyc();
    end
    check("pre_rst_pend", 32'(pend_b), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mrst_we", 32'(WE), 32'd0);
    check("mrst_rw", 32'(RW), 32'd0);
    check("mrst_wd", WD, 32'd0);
    check("mrst_pc", pc, 32'd0);
    check("mrst_ready", 32'(md_ready), 32'd1);
    check("mrst_pend", 32'(pend_b), 32'd0);
    idle();
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("post_rst_we", 32'(WE), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
